// File: rtl/io_intr_pkg.sv
// Shared definitions for the IO interrupt controller: FSM states, register map, reset values.
package io_intr_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSERT   = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    localparam logic       MASK_ADDR = 1'b0;
    localparam logic       CLR_ADDR  = 1'b1;
    localparam logic [7:0] MASK_RST  = 8'hFF;

endpackage

// File: rtl/io_intr_prio_enc.sv
// Fixed-priority selector: any enabled fast bit [7:4] beats any normal bit [3:0];
// within a class the lowest index wins.
module io_intr_prio_enc (
    input  logic [7:0] pending,
    input  logic [7:0] mask,
    output logic       valid,
    output logic       fast,
    output logic [1:0] index
);

    logic [7:0] req;
    logic [3:0] grp;

    always_comb begin
        req   = pending & mask;
        valid = |req;
        fast  = |req[7:4];
        grp   = fast ? req[7:4] : req[3:0];
        index = '0;
        // Scan downward so the lowest set bit is written last.
        for (int unsigned i = 4; i > 0; i--) begin
            if (grp[i-1]) index = 2'(i - 1);
        end
    end

endmodule

// File: rtl/io_intr_ctrl.sv
// IO interrupt controller: edge-detected pending bits, enable mask, IDLE/ASSERT/WAIT_REL handshake.
// Optional ASSERT watchdog enabled by defining IO_INTR_TIMEOUT_EN.
module io_intr_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [3:0]  irq_req,
    input  logic [3:0]  firq_req,
    input  logic        int_ack,
    input  logic        CS_,
    input  logic        WR_,
    input  logic        Addr,
    input  logic [31:0] Data,
    output logic        intr,
    output logic        fintr,
    output logic [1:0]  intr_num,
    output logic [7:0]  pending,
    output logic        timeout_err
);
    import io_intr_pkg::*;

    state_t     state;
    logic [7:0] mask;
    logic [7:0] req_prev;
    logic [7:0] sel;
    logic       ack_prev;
    logic [7:0] req_now;
    logic [7:0] rise;
    logic [7:0] clr;
    logic       ack_rise;
    logic       reg_wr;
    logic       tmo;
    logic       enc_valid;
    logic       enc_fast;
    logic [1:0] enc_index;
    logic [23:0] unused_data;

    assign req_now     = {firq_req, irq_req};
    assign rise        = req_now & ~req_prev;
    assign ack_rise    = int_ack & ~ack_prev;
    assign reg_wr      = !CS_ && !WR_;
    assign unused_data = Data[31:8];

    io_intr_prio_enc u_prio (
        .pending (pending),
        .mask    (mask),
        .valid   (enc_valid),
        .fast    (enc_fast),
        .index   (enc_index)
    );

    always_comb begin
        clr = '0;
        if (reg_wr && Addr == CLR_ADDR) clr = Data[7:0];
        if (state == ASSERT && (ack_rise || tmo)) clr = clr | sel;
    end

`ifdef IO_INTR_TIMEOUT_EN
    logic [31:0] tmo_cnt;
    logic        tmo_err;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            tmo_cnt <= '0;
            tmo_err <= 1'b0;
        end else begin
            tmo_cnt <= (state == ASSERT && !tmo) ? tmo_cnt + 32'd1 : '0;
            if (tmo && !ack_rise) tmo_err <= 1'b1;
        end
    end

    assign tmo         = (state == ASSERT) && (tmo_cnt == TIMEOUT - 32'd1);
    assign timeout_err = tmo_err;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign tmo            = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    // A new edge on a bit being cleared wins because rise is OR-ed after the clear.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            intr     <= 1'b0;
            fintr    <= 1'b0;
            intr_num <= '0;
            pending  <= '0;
            mask     <= MASK_RST;
            sel      <= '0;
            req_prev <= '0;
            ack_prev <= 1'b0;
        end else begin
            req_prev <= req_now;
            ack_prev <= int_ack;
            pending  <= (pending & ~clr) | rise;
            if (reg_wr && Addr == MASK_ADDR) mask <= Data[7:0];
            case (state)
                IDLE: begin
                    if (enc_valid) begin
                        state    <= ASSERT;
                        intr_num <= enc_index;
                        fintr    <= enc_fast;
                        intr     <= !enc_fast;
                        sel      <= 8'd1 << {enc_fast, enc_index};
                    end
                end
                ASSERT: begin
                    if (ack_rise) begin
                        intr  <= 1'b0;
                        fintr <= 1'b0;
                        state <= WAIT_REL;
                    end else if (tmo) begin
                        intr  <= 1'b0;
                        fintr <= 1'b0;
                        state <= IDLE;
                    end
                end
                WAIT_REL: begin
                    if (!int_ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_intr_ctrl.sv
// Scoreboard bench for io_intr_ctrl: stimulus queues expected interrupt assertions,
// a negedge monitor pops and checks them; status checks are made inline.
module tb_io_intr_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [3:0]  irq_req;
    logic [3:0]  firq_req;
    logic        int_ack;
    logic        CS_;
    logic        WR_;
    logic        Addr;
    logic [31:0] Data;
    logic        intr;
    logic        fintr;
    logic [1:0]  intr_num;
    logic [7:0]  pending;
    logic        timeout_err;

    typedef struct packed {
        logic       fast;
        logic [1:0] num;
        int         cycle;
    } exp_t;

    exp_t sb[$];
    int   cmp_cnt = 0;
    int   fail_cnt = 0;
    int   cyc = 0;
    logic out_prev = 1'b0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    io_intr_ctrl #(.TIMEOUT(4)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .irq_req     (irq_req),
        .firq_req    (firq_req),
        .int_ack     (int_ack),
        .CS_         (CS_),
        .WR_         (WR_),
        .Addr        (Addr),
        .Data        (Data),
        .intr        (intr),
        .fintr       (fintr),
        .intr_num    (intr_num),
        .pending     (pending),
        .timeout_err (timeout_err)
    );

    // Monitor: every rising assertion of intr/fintr must match the head of the scoreboard.
    always @(negedge Clk) begin
        exp_t e;
        logic out_now;
        out_now = (intr === 1'b1) || (fintr === 1'b1);
        if (out_now) begin
            cmp_cnt++;
            if (intr === 1'b1 && fintr === 1'b1) begin
                fail_cnt++;
                $display("FAIL exclusive: intr=%0b fintr=%0b, required at most one high", intr, fintr);
            end
        end
        if (out_now && !out_prev) begin
            cmp_cnt++;
            if (sb.size() == 0) begin
                fail_cnt++;
                $display("FAIL unexpected_irq: got fintr=%0b intr=%0b num=%0d at cycle %0d, required none",
                         fintr, intr, intr_num, cyc);
            end else begin
                e = sb.pop_front();
                if ({fintr, intr, intr_num, cyc} !== {e.fast, ~e.fast, e.num, e.cycle}) begin
                    fail_cnt++;
                    $display("FAIL irq_assert: got fintr=%0b intr=%0b num=%0d cycle=%0d, required fintr=%0b intr=%0b num=%0d cycle=%0d",
                             fintr, intr, intr_num, cyc, e.fast, ~e.fast, e.num, e.cycle);
                end
            end
        end
        out_prev = out_now;
    end

    task automatic step(int n = 1);
        repeat (n) @(negedge Clk);
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        cmp_cnt++;
        if (got !== want) begin
            fail_cnt++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic expect_irq(logic fast, logic [1:0] num, int cycle);
        exp_t e;
        e.fast  = fast;
        e.num   = num;
        e.cycle = cycle;
        sb.push_back(e);
    endtask

    task automatic reg_write(logic a, logic [7:0] d);
        CS_  = 1'b0;
        WR_  = 1'b0;
        Addr = a;
        Data = {24'hA5A5A5, d};
        step();
        CS_  = 1'b1;
        WR_  = 1'b1;
        Data = '0;
    endtask

    task automatic ack_pulse();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        step();
    endtask

    task automatic idle_all();
        irq_req  = '0;
        firq_req = '0;
        step(2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int d;
        Reset = 1'b1; irq_req = '0; firq_req = '0; int_ack = 1'b0;
        CS_ = 1'b1; WR_ = 1'b1; Addr = 1'b0; Data = '0;
        step(3);
        Reset = 1'b0;
        chk("reset_outputs", {29'd0, intr, fintr, intr_num}, 32'd0);
        chk("reset_pending", {24'd0, pending}, 32'd0);
        chk("reset_timeout_err", {31'd0, timeout_err}, 32'd0);

        // Single fast request with two-edge latency, then ack.
        d = cyc;
        firq_req = 4'b0100;
        expect_irq(1'b1, 2'd2, d + 2);
        step();
        chk("A_pending_set", {24'd0, pending}, 32'h40);
        chk("A_no_output_yet", {30'd0, intr, fintr}, 32'd0);
        step();
        int_ack = 1'b1;
        step();
        chk("A_drop_after_ack", {30'd0, intr, fintr}, 32'd0);
        chk("A_pending_cleared", {24'd0, pending}, 32'h00);
        int_ack = 1'b0;
        step();
        idle_all();

        // Simultaneous normal and fast: fast first, normal after release.
        d = cyc;
        irq_req  = 4'b0010;
        firq_req = 4'b1000;
        expect_irq(1'b1, 2'd3, d + 2);
        expect_irq(1'b0, 2'd1, d + 5);
        step();
        chk("B_pending_both", {24'd0, pending}, 32'h82);
        step();
        int_ack = 1'b1;
        step();
        chk("B_fast_dropped", {30'd0, intr, fintr}, 32'd0);
        chk("B_pending_normal", {24'd0, pending}, 32'h02);
        int_ack = 1'b0;
        step();
        chk("B_low_gap", {30'd0, intr, fintr}, 32'd0);
        step();
        ack_pulse();
        idle_all();

        // Masked fast request stays pending without output until enabled.
        reg_write(1'b0, 8'h0F);
        firq_req = 4'b0001;
        step(2);
        chk("C_masked_pending", {24'd0, pending}, 32'h10);
        chk("C_masked_no_output", {30'd0, intr, fintr}, 32'd0);
        d = cyc;
        expect_irq(1'b1, 2'd0, d + 2);
        reg_write(1'b0, 8'hFF);
        step();
        ack_pulse();
        idle_all();

        // Set beats write-1-clear on the same bit; plain clear afterwards.
        reg_write(1'b0, 8'h00);
        irq_req = 4'b0010;
        reg_write(1'b1, 8'h02);
        chk("S_set_wins", {24'd0, pending}, 32'h02);
        reg_write(1'b1, 8'h02);
        chk("S_w1c", {24'd0, pending}, 32'h00);
        irq_req = '0;
        reg_write(1'b0, 8'hFF);
        step();

        // Reset during ASSERT; mask change first must not retract the output.
        d = cyc;
        irq_req = 4'b0001;
        expect_irq(1'b0, 2'd0, d + 2);
        step(2);
        reg_write(1'b0, 8'h00);
        chk("D_mask_no_retract", {30'd0, intr, fintr}, 32'h2);
        Reset = 1'b1;
        irq_req = '0;
        step();
        Reset = 1'b0;
        chk("D_reset_outputs", {29'd0, intr, fintr, intr_num}, 32'd0);
        chk("D_reset_pending", {24'd0, pending}, 32'd0);
        step(3);
        chk("D_not_resignalled", {30'd0, intr, fintr}, 32'd0);
        d = cyc;
        firq_req = 4'b0010;
        expect_irq(1'b1, 2'd1, d + 2);
        step(2);
        ack_pulse();
        idle_all();

        // Long ack clears exactly one source; next waits for ack release.
        d = cyc;
        irq_req = 4'b1100;
        expect_irq(1'b0, 2'd2, d + 2);
        expect_irq(1'b0, 2'd3, d + 9);
        step(2);
        int_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("E_held_ack_low", {31'd0, intr}, 32'd0);
            chk("E_one_cleared", {24'd0, pending}, 32'h08);
        end
        int_ack = 1'b0;
        step(2);
        ack_pulse();
        idle_all();

        // New edge on the acknowledged source in the ack cycle keeps it pending.
        d = cyc;
        irq_req = 4'b0001;
        expect_irq(1'b0, 2'd0, d + 2);
        expect_irq(1'b0, 2'd0, d + 6);
        step(2);
        irq_req = '0;
        step();
        irq_req = 4'b0001;
        int_ack = 1'b1;
        step();
        chk("F_pending_kept", {24'd0, pending}, 32'h01);
        chk("F_output_low", {31'd0, intr}, 32'd0);
        int_ack = 1'b0;
        step(2);
        ack_pulse();
        idle_all();

        // No ack: forced drop with timeout, or indefinite hold without it.
        d = cyc;
        irq_req = 4'b0100;
        expect_irq(1'b0, 2'd2, d + 2);
        step(2);
`ifdef IO_INTR_TIMEOUT_EN
        step(3);
        chk("T_still_high", {31'd0, intr}, 32'd1);
        step();
        chk("T_dropped", {31'd0, intr}, 32'd0);
        chk("T_err_set", {31'd0, timeout_err}, 32'd1);
        chk("T_pending_cleared", {24'd0, pending}, 32'd0);
        step(2);
        chk("T_no_resignal", {31'd0, intr}, 32'd0);
`else
        step(10);
        chk("T_held", {31'd0, intr}, 32'd1);
        chk("T_err_tied", {31'd0, timeout_err}, 32'd0);
        ack_pulse();
`endif
        idle_all();

        step(3);
        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
